// File: rtl/hazard_scoreboard_if.sv
// Signal bundle between the pipeline datapath/control and hazard_scoreboard.
// The datapath side uses the master modport; the hazard unit uses slave.
interface hazard_scoreboard_if #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5
);
  logic [REG_AW-1:0]   Rs1D, Rs2D, RdD;
  logic                RegWriteD, LongOpD;
  logic [REG_AW-1:0]   Rs1E, Rs2E, RdE;
  logic                ResultSrcEb0, PCSrcE, LongIssueE;
  logic [REG_AW-1:0]   RdM, RdW;
  logic                RegWriteM, RegWriteW;
  logic                LongDoneV;
  logic [REG_AW-1:0]   LongDoneRd;
  logic [1:0]          ForwardAE, ForwardBE;
  logic                StallF, StallD, FlushD, FlushE;
  logic [NUM_REGS-1:0] SbBusy;
  logic                SbError;
  logic [31:0]         PerfStallCnt, PerfFlushCnt;

  modport slave (
    input  Rs1D, Rs2D, RdD, RegWriteD, LongOpD, Rs1E, Rs2E, RdE, ResultSrcEb0,
           PCSrcE, LongIssueE, RdM, RdW, RegWriteM, RegWriteW, LongDoneV, LongDoneRd,
    output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, SbBusy, SbError,
           PerfStallCnt, PerfFlushCnt
  );

  modport master (
    output Rs1D, Rs2D, RdD, RegWriteD, LongOpD, Rs1E, Rs2E, RdE, ResultSrcEb0,
           PCSrcE, LongIssueE, RdM, RdW, RegWriteM, RegWriteW, LongDoneV, LongDoneRd,
    input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE, SbBusy, SbError,
           PerfStallCnt, PerfFlushCnt
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Five-stage hazard unit: M/W forwarding, load-use stall, branch flush and a
// per-register scoreboard for long-latency ops. Optional perf counters: HAZARD_SB_PERF_EN.
module hazard_scoreboard #(
  parameter int NUM_REGS  = 32,
  parameter int REG_AW    = 5,
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = 4
) (
  input logic clock,
  input logic reset,
  hazard_scoreboard_if.slave hz
);

  // Long-op events are single-cycle pulses with no backpressure: LongIssueE
  // marks one op leaving Execute toward RdE, LongDoneV marks one result being
  // written to LongDoneRd in that same cycle. Each pulse is one transfer.
  logic [NUM_REGS-1:0] busyQ, doneMask, issueMask, effBusy;
  logic [CNT_W-1:0]    outstQ;
  logic                sbErrorQ;
  logic                atMax, atZero, badIssue, badDone;
  logic                lwStall, rawStall, wawStall, fullStall, stall;

  always_comb begin
    doneMask  = '0;
    issueMask = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (hz.LongDoneV && hz.LongDoneRd == REG_AW'(r)) doneMask[r] = 1'b1;
      if (hz.LongIssueE && hz.RdE == REG_AW'(r))       issueMask[r] = 1'b1;
    end
  end

  // A completing register reads as free this cycle: the regfile write lands first.
  assign effBusy = busyQ & ~doneMask;

  assign atMax    = (outstQ == CNT_W'(MAX_OUTST));
  assign atZero   = (outstQ == '0);
  assign badIssue = hz.LongIssueE && !hz.LongDoneV && atMax;
  assign badDone  = hz.LongDoneV && atZero;

  always_comb begin
    hz.ForwardAE = 2'b00;
    if (hz.Rs1E != '0) begin
      if (hz.RegWriteM && hz.Rs1E == hz.RdM)      hz.ForwardAE = 2'b10;
      else if (hz.RegWriteW && hz.Rs1E == hz.RdW) hz.ForwardAE = 2'b01;
    end
  end

  always_comb begin
    hz.ForwardBE = 2'b00;
    if (hz.Rs2E != '0) begin
      if (hz.RegWriteM && hz.Rs2E == hz.RdM)      hz.ForwardBE = 2'b10;
      else if (hz.RegWriteW && hz.Rs2E == hz.RdW) hz.ForwardBE = 2'b01;
    end
  end

  assign lwStall   = hz.ResultSrcEb0 && (hz.RdE != '0) &&
                     ((hz.Rs1D == hz.RdE) || (hz.Rs2D == hz.RdE));
  assign rawStall  = ((hz.Rs1D != '0) && effBusy[hz.Rs1D]) ||
                     ((hz.Rs2D != '0) && effBusy[hz.Rs2D]);
  assign wawStall  = (hz.RegWriteD || hz.LongOpD) && (hz.RdD != '0) && effBusy[hz.RdD];
  assign fullStall = hz.LongOpD && atMax && !hz.LongDoneV;
  assign stall     = lwStall || rawStall || wawStall || fullStall;

  // Decode sees both stall and flush on a taken branch; its register lets flush win.
  assign hz.StallF  = stall;
  assign hz.StallD  = stall;
  assign hz.FlushD  = hz.PCSrcE;
  assign hz.FlushE  = stall || hz.PCSrcE;
  assign hz.SbBusy  = busyQ;
  assign hz.SbError = sbErrorQ;

  always_ff @(posedge clock) begin
    if (reset) begin
      busyQ    <= '0;
      outstQ   <= '0;
      sbErrorQ <= 1'b0;
    end else begin
      // Clear before set so a same-cycle issue/done on one register stays busy.
      busyQ <= (busyQ & ~doneMask) | issueMask;
      if (hz.LongIssueE && !hz.LongDoneV && !atMax)
        outstQ <= outstQ + CNT_W'(1);
      else if (hz.LongDoneV && !hz.LongIssueE && !atZero)
        outstQ <= outstQ - CNT_W'(1);
      if (badIssue || badDone)
        sbErrorQ <= 1'b1;
    end
  end

`ifdef HAZARD_SB_PERF_EN
  logic [31:0] perfStallQ, perfFlushQ;

  always_ff @(posedge clock) begin
    if (reset) begin
      perfStallQ <= '0;
      perfFlushQ <= '0;
    end else begin
      if (stall && perfStallQ != 32'hFFFF_FFFF)     perfStallQ <= perfStallQ + 32'd1;
      if (hz.PCSrcE && perfFlushQ != 32'hFFFF_FFFF) perfFlushQ <= perfFlushQ + 32'd1;
    end
  end

  assign hz.PerfStallCnt = perfStallQ;
  assign hz.PerfFlushCnt = perfFlushQ;
`else
  assign hz.PerfStallCnt = 32'd0;
  assign hz.PerfFlushCnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: a rule-level reference model checked
// every cycle, plus literal expectations at the interesting points.
module tb_hazard_scoreboard;
  localparam int MAXO = 4;

  logic clock = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  bit   checkEn = 1'b0;

  hazard_scoreboard_if #(.NUM_REGS(32), .REG_AW(5)) hz();

  hazard_scoreboard #(.NUM_REGS(32), .REG_AW(5), .MAX_OUTST(MAXO), .CNT_W(4)) dut (
    .clock (clock),
    .reset (reset),
    .hz    (hz)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  bit    mBusy[32];
  int    mOut;
  bit    mErr;
  longint mStallCnt, mFlushCnt;

  function automatic bit effB(input int r);
    return (r != 0) && mBusy[r] && !(hz.LongDoneV && int'(hz.LongDoneRd) == r);
  endfunction

  function automatic logic [1:0] fwd(input int rs);
    if (rs == 0) return 2'b00;
    if (hz.RegWriteM && rs == int'(hz.RdM)) return 2'b10;
    if (hz.RegWriteW && rs == int'(hz.RdW)) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit expStall();
    bit lw, raw, waw, full;
    lw   = hz.ResultSrcEb0 && hz.RdE != 0 && (hz.Rs1D == hz.RdE || hz.Rs2D == hz.RdE);
    raw  = effB(int'(hz.Rs1D)) || effB(int'(hz.Rs2D));
    waw  = (hz.RegWriteD || hz.LongOpD) && effB(int'(hz.RdD));
    full = hz.LongOpD && mOut == MAXO && !hz.LongDoneV;
    return lw || raw || waw || full;
  endfunction

  function automatic logic [31:0] busyVec();
    logic [31:0] v;
    v = '0;
    for (int r = 0; r < 32; r++) v[r] = mBusy[r];
    return v;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < 32; r++) mBusy[r] = 1'b0;
      mOut = 0; mErr = 1'b0; mStallCnt = 0; mFlushCnt = 0;
    end else begin
      if (expStall() && mStallCnt < 64'hFFFF_FFFF) mStallCnt++;
      if (hz.PCSrcE && mFlushCnt < 64'hFFFF_FFFF)  mFlushCnt++;
      if (hz.LongDoneV && mOut == 0) mErr = 1'b1;
      if (hz.LongIssueE && !hz.LongDoneV && mOut == MAXO) mErr = 1'b1;
      if (hz.LongIssueE && !hz.LongDoneV && mOut < MAXO) mOut++;
      if (hz.LongDoneV && !hz.LongIssueE && mOut > 0) mOut--;
      if (hz.LongDoneV) mBusy[hz.LongDoneRd] = 1'b0;
      if (hz.LongIssueE && hz.RdE != 0) mBusy[hz.RdE] = 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (checkEn) begin
      bit s;
      s = expStall();
      chk("m_fwdA", 32'(hz.ForwardAE), 32'(fwd(int'(hz.Rs1E))));
      chk("m_fwdB", 32'(hz.ForwardBE), 32'(fwd(int'(hz.Rs2E))));
      chk("m_stallF", 32'(hz.StallF), 32'(s));
      chk("m_stallD", 32'(hz.StallD), 32'(s));
      chk("m_flushD", 32'(hz.FlushD), 32'(hz.PCSrcE));
      chk("m_flushE", 32'(hz.FlushE), 32'(s || hz.PCSrcE));
      chk("m_busy", hz.SbBusy, busyVec());
      chk("m_err", 32'(hz.SbError), 32'(mErr));
`ifdef HAZARD_SB_PERF_EN
      chk("m_perfStall", hz.PerfStallCnt, mStallCnt[31:0]);
      chk("m_perfFlush", hz.PerfFlushCnt, mFlushCnt[31:0]);
`else
      chk("m_perfStall", hz.PerfStallCnt, 32'd0);
      chk("m_perfFlush", hz.PerfFlushCnt, 32'd0);
`endif
    end
  end

  // ---------------- driver ----------------
  task automatic idle();
    hz.Rs1D = '0; hz.Rs2D = '0; hz.RdD = '0; hz.RegWriteD = 1'b0; hz.LongOpD = 1'b0;
    hz.Rs1E = '0; hz.Rs2E = '0; hz.RdE = '0; hz.ResultSrcEb0 = 1'b0; hz.PCSrcE = 1'b0;
    hz.LongIssueE = 1'b0; hz.RdM = '0; hz.RdW = '0; hz.RegWriteM = 1'b0;
    hz.RegWriteW = 1'b0; hz.LongDoneV = 1'b0; hz.LongDoneRd = '0;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic atNeg();
    @(negedge clock);
  endtask

  task automatic issue(input int rd);
    idle(); hz.LongIssueE = 1'b1; hz.RdE = 5'(rd); tick();
  endtask

  task automatic done(input int rd);
    idle(); hz.LongDoneV = 1'b1; hz.LongDoneRd = 5'(rd); tick();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    checkEn = 1'b1;
    tick();
    reset = 1'b0;

    // reset state with idle inputs
    atNeg();
    chk("rst_busy", hz.SbBusy, 32'h0);
    chk("rst_err", 32'(hz.SbError), 32'h0);
    chk("rst_ctrl", {28'h0, hz.StallF, hz.StallD, hz.FlushD, hz.FlushE}, 32'h0);
    tick();

    // forwarding: M priority, x0 never forwards, W when M does not write
    hz.RdM = 5'd5; hz.RegWriteM = 1'b1; hz.RdW = 5'd5; hz.RegWriteW = 1'b1; hz.Rs1E = 5'd5;
    atNeg(); chk("fwd_m_prio", 32'(hz.ForwardAE), 32'h2); tick();
    hz.Rs1E = 5'd0;
    atNeg(); chk("fwd_x0", 32'(hz.ForwardAE), 32'h0); tick();
    hz.RegWriteM = 1'b0; hz.Rs2E = 5'd5;
    atNeg(); chk("fwd_w", 32'(hz.ForwardBE), 32'h1); tick();

    // load-use: stall one cycle, then forward from M
    idle(); hz.ResultSrcEb0 = 1'b1; hz.RdE = 5'd7; hz.Rs2D = 5'd7;
    atNeg(); chk("lw_stall", {29'h0, hz.StallF, hz.StallD, hz.FlushE}, 32'h7); tick();
    idle(); hz.RdM = 5'd7; hz.RegWriteM = 1'b1; hz.Rs2E = 5'd7;
    atNeg();
    chk("lw_fwd", 32'(hz.ForwardBE), 32'h2);
    chk("lw_nostall", 32'(hz.StallD), 32'h0);
    tick();

    // long op RAW on x9 until done; bypass drops the stall in the done cycle
    issue(9);
    for (int i = 0; i < 3; i++) begin
      idle(); hz.Rs1D = 5'd9;
      atNeg(); chk("raw_stall", 32'(hz.StallD), 32'h1); tick();
    end
    idle(); hz.Rs1D = 5'd9; hz.LongDoneV = 1'b1; hz.LongDoneRd = 5'd9;
    atNeg();
    chk("raw_bypass", 32'(hz.StallD), 32'h0);
    chk("raw_busy_still", 32'(hz.SbBusy[9]), 32'h1);
    tick();
    idle();
    atNeg(); chk("raw_busy_clr", 32'(hz.SbBusy[9]), 32'h0); tick();

    // outstanding limit
    for (int r = 1; r <= 4; r++) issue(r);
    idle(); hz.LongOpD = 1'b1; hz.RdD = 5'd10; hz.RegWriteD = 1'b1;
    atNeg();
    chk("full_busy", hz.SbBusy, 32'h0000_001E);
    chk("full_stall", 32'(hz.StallD), 32'h1);
    tick();
    hz.LongDoneV = 1'b1; hz.LongDoneRd = 5'd1;
    atNeg(); chk("full_release", 32'(hz.StallD), 32'h0); tick();
    for (int r = 2; r <= 4; r++) done(r);

    // same-register issue+done keeps busy; WAW stall on busy destination
    issue(6);
    idle(); hz.LongIssueE = 1'b1; hz.RdE = 5'd6; hz.LongDoneV = 1'b1; hz.LongDoneRd = 5'd6;
    tick();
    idle(); hz.RdD = 5'd6; hz.RegWriteD = 1'b1;
    atNeg();
    chk("setwins_busy", hz.SbBusy, 32'h0000_0040);
    chk("waw_stall", 32'(hz.StallD), 32'h1);
    tick();
    done(6);

    // issue toward x0 counts; matching done on x0 is legal
    issue(0);
    done(0);
    idle();
    atNeg(); chk("x0_legal", {31'h0, hz.SbError}, 32'h0); tick();

    // branch flush, and flush together with a stall
    idle(); hz.PCSrcE = 1'b1;
    atNeg(); chk("br_flush", {28'h0, hz.StallF, hz.StallD, hz.FlushD, hz.FlushE}, 32'h3); tick();
    hz.ResultSrcEb0 = 1'b1; hz.RdE = 5'd3; hz.Rs1D = 5'd3;
    atNeg(); chk("br_stall", {28'h0, hz.StallF, hz.StallD, hz.FlushD, hz.FlushE}, 32'hF); tick();

    // done with nothing outstanding is sticky until reset
    done(12);
    idle();
    atNeg(); chk("err_set", 32'(hz.SbError), 32'h1); tick();
    atNeg(); chk("err_hold", 32'(hz.SbError), 32'h1); tick();
    reset = 1'b1; tick(); reset = 1'b0;
    atNeg();
    chk("err_rst", 32'(hz.SbError), 32'h0);
    chk("busy_rst", hz.SbBusy, 32'h0);
    tick();

    // issue beyond the limit flags an error and the counter holds at max
    for (int r = 11; r <= 15; r++) issue(r);
    idle(); hz.LongOpD = 1'b1; hz.RdD = 5'd20;
    atNeg();
    chk("ovf_err", 32'(hz.SbError), 32'h1);
    chk("ovf_hold_full", 32'(hz.StallD), 32'h1);
    tick();
    idle(); reset = 1'b1; tick(); reset = 1'b0;

    // perf: three stall cycles then two branch cycles
    for (int i = 0; i < 3; i++) begin
      idle(); hz.ResultSrcEb0 = 1'b1; hz.RdE = 5'd8; hz.Rs1D = 5'd8; tick();
    end
    for (int i = 0; i < 2; i++) begin
      idle(); hz.PCSrcE = 1'b1; tick();
    end
    idle();
    atNeg();
`ifdef HAZARD_SB_PERF_EN
    chk("perf_stall", hz.PerfStallCnt, 32'd3);
    chk("perf_flush", hz.PerfFlushCnt, 32'd2);
`else
    chk("perf_stall_off", hz.PerfStallCnt, 32'd0);
    chk("perf_flush_off", hz.PerfFlushCnt, 32'd0);
`endif
    tick();
    tick();

    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the pipelined core's hazard unit.
- Keeps classic M/W forwarding, load-use stall and branch flush.
- Adds a registered per-register scoreboard for variable-latency operations (divider, wait-state memory) that issue from Execute and write back out of order, plus an outstanding-op limit.
- Sits between the datapath and the control unit; drives the stall, flush and forward controls of the five-stage pipeline.

Parameters:
- NUM_REGS, 32: architectural registers; x0 is never tracked.
- REG_AW, 5: register address width, must equal clog2(NUM_REGS).
- MAX_OUTST, 4: maximum in-flight long-latency ops (1..15).
- CNT_W, 4: outstanding counter width; must hold MAX_OUTST.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- Rs1D, Rs2D, RdD  in  REG_AW  Decode source and destination registers.
- RegWriteD  in  1  Decode instruction writes RdD.
- LongOpD  in  1  Decode instruction is long-latency.
- Rs1E, Rs2E, RdE  in  REG_AW  Execute registers.
- ResultSrcEb0  in  1  Execute instruction is a load.
- PCSrcE  in  1  branch/jump taken in Execute.
- LongIssueE  in  1  long op leaves Execute this cycle toward unit RdE.
- RdM, RdW  in  REG_AW  Memory and Writeback destinations.
- RegWriteM, RegWriteW  in  1  Memory and Writeback write enables.
- LongDoneV  in  1  long op completes; result written this cycle.
- LongDoneRd  in  REG_AW  completing destination.
- ForwardAE, ForwardBE  out  2  00 regfile, 10 from M, 01 from W.
- StallF, StallD, FlushD, FlushE  out  1  pipeline controls.
- SbBusy  out  NUM_REGS  registered busy vector; bit 0 is always 0.
- SbError  out  1  sticky protocol error.
- PerfStallCnt, PerfFlushCnt  out  32  optional counters.

Behaviour:
- Reset: busy all 0, outstanding=0, SbError=0, perf counters 0.
- Outputs are combinational from the state above and current inputs, so all controls read 0 immediately after reset when the inputs are idle.
- Forwarding, per operand: if Rs==0, 00. Else if Rs==RdM and RegWriteM, 10 (M has priority). Else if Rs==RdW and RegWriteW, 01. Else 00.
- lwStall = ResultSrcEb0 & (RdE!=0) & (Rs1D==RdE | Rs2D==RdE).
- Busy-clear bypass: a register is treated as not busy in the cycle LongDoneV names it. The regfile writes in the first half-cycle, so no extra stall is needed.
- rawStall: any nonzero Rs1D/Rs2D whose effective busy bit is set.
- wawStall: (RegWriteD | LongOpD), RdD!=0, and the effective busy bit of RdD is set.
- fullStall: LongOpD & (outstanding==MAX_OUTST) & !(LongDoneV at that moment).
- stall = lwStall | rawStall | wawStall | fullStall.
- Control outputs: StallF = StallD = stall; FlushE = stall | PCSrcE; FlushD = PCSrcE.
- PCSrcE together with stall: StallD=1 and FlushD=1; the Decode register gives flush priority.
- Scoreboard update at the clock edge:
  - LongIssueE with RdE!=0 sets busy[RdE].
  - LongDoneV clears busy[LongDoneRd].
  - Issue and done on the same register in the same cycle: set wins.
- Outstanding counter:
  - +1 on LongIssueE, -1 on LongDoneV; both in one cycle leaves it unchanged.
  - Issue with RdE==0 still counts.
  - The counter never wraps.
- SbError set (sticky until reset) on either illegal event; the counter holds in both cases:
  - Issue while outstanding==MAX_OUTST with no simultaneous done.
  - Done while outstanding==0.
- Done naming a non-busy register, with outstanding>0, is legal (x0 destination).
- Reset asserted mid-operation drops all in-flight tracking. The Execute unit is reset by the same signal.

Optional Feature:
- Macro: HAZARD_SB_PERF_EN.
- Defined:
  - PerfStallCnt increments every cycle StallD=1.
  - PerfFlushCnt increments every cycle PCSrcE=1.
  - Both are 32-bit and saturate at 0xFFFFFFFF.
  - Both are cleared by reset.
- Undefined: no counter registers; both outputs are constant 0.

Test Plan:
- RdM=5 with RegWriteM=1, RdW=5 with RegWriteW=1, Rs1E=5 -> ForwardAE=10. Same with Rs1E=0 -> ForwardAE=00.
- Load in E with RdE=7, Rs2D=7 -> StallF=StallD=FlushE=1 for one cycle. The next cycle, with load in M, ForwardBE=10 and no stall.
- LongIssueE RdE=9, then Rs1D=9 held -> stall each cycle until LongDoneV with LongDoneRd=9. Stall drops in the done cycle and SbBusy[9]=0 the cycle after.
- Issue 4 long ops (MAX_OUTST=4), LongOpD=1 -> StallD=1. One LongDoneV -> stall released in that same cycle.
- Done with outstanding=0 -> SbError=1 and held. Reset -> SbError=0, SbBusy=0.
- Under HAZARD_SB_PERF_EN: 3 stall cycles and 2 PCSrcE cycles -> PerfStallCnt=3, PerfFlushCnt=2. Preloaded 0xFFFFFFFF holds.
